mem_access_ctrl: RTL

Processor-side initiator for the 8-bit unified memory/stack block. It accepts fetch, load, store, push and pop commands from the control unit and drives the memory's single-cycle `read`/`write`/`push`/`pop` strobes. It owns the program counter and stack pointer, and sequences variable-length instruction fetch: 1 byte, 2 bytes, or 2 bytes plus an indirect operand. It sits between the control unit and `memory`.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/instr_len_decode.sv | 23 ++
 rtl/mem_access_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the processor-side memory access controller.
package mem_pkg;

    localparam int unsigned MEM_DEPTH_DEF   = 24;
    localparam int unsigned STACK_DEPTH_DEF = 8;

    // Opcode high nibbles that carry a second byte; OPC_IND also carries an indirect operand
    localparam logic [3:0] OPC_ARG3 = 4'b0011;
    localparam logic [3:0] OPC_IND  = 4'b0100;
    localparam logic [3:0] OPC_ARG5 = 4'b0101;
    localparam logic [3:0] OPC_ARG8 = 4'b1000;
    localparam logic [3:0] OPC_ARG9 = 4'b1001;
    localparam logic [3:0] OPC_ARGA = 4'b1010;

    typedef enum logic [2:0] {
        CMD_FETCH = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_STORE = 3'd2,
        CMD_PUSH  = 3'd3,
        CMD_POP   = 3'd4
    } cmd_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F_OP,
        ST_F_ARG,
        ST_F_IND,
        ST_LOAD,
        ST_STORE,
        ST_PUSH,
        ST_POP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Command/response handshake between the control unit (master) and the access controller (slave).
interface mem_access_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       pc_load;
    logic [7:0] pc_value;
    logic       rsp_valid;
    logic       rsp_err;
    logic [7:0] rsp_data;
    logic [7:0] rsp_arg;
    logic [7:0] rsp_ind;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, pc_load, pc_value,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data, rsp_arg, rsp_ind
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, pc_load, pc_value,
        output cmd_ready, rsp_valid, rsp_err, rsp_data, rsp_arg, rsp_ind
    );

endinterface

// File: rtl/instr_len_decode.sv
// Instruction length decoder: opcode high nibble -> {has second byte, has indirect operand}.
module instr_len_decode
    import mem_pkg::*;
(
    input  logic [3:0] opc_i,
    output logic       has_arg_o,
    output logic       has_ind_o
);

    always_comb begin
        has_arg_o = 1'b0;
        has_ind_o = 1'b0;
        case (opc_i)
            OPC_ARG3, OPC_ARG5, OPC_ARG8, OPC_ARG9, OPC_ARGA: has_arg_o = 1'b1;
            OPC_IND: begin
                has_arg_o = 1'b1;
                has_ind_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Processor-side memory/stack initiator: owns PC and SP, sequences variable-length fetch.
// Optional feature: define MEM_BOUNDS_CHECK_EN to suppress accesses at addresses >= MEM_DEPTH.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [7:0]  PC_RESET    = 8'd0
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave cmd_if,
    output logic [7:0]       pc,
    output logic [7:0]       sp,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_push,
    output logic             mem_pop,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata
);

    localparam logic [8:0] MEM_LIM   = 9'(MEM_DEPTH);
    localparam logic [7:0] STACK_LIM = 8'(STACK_DEPTH);
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    function automatic logic oob(input logic [7:0] a);
        return BOUNDS_EN && ({1'b0, a} >= MEM_LIM);
    endfunction

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] data_q, data_d;
    logic [7:0] arg_q, arg_d;
    logic [7:0] ind_q, ind_d;
    logic       err_q, err_d;

    logic [3:0] dec_opc;
    logic       has_arg;
    logic       has_ind;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_err;

    // F_OP decodes the byte on the bus; F_ARG decodes the opcode already captured
    assign dec_opc = (state_q == ST_F_OP) ? mem_rdata[7:4] : data_q[7:4];

    instr_len_decode u_len_dec (
        .opc_i     (dec_opc),
        .has_arg_o (has_arg),
        .has_ind_o (has_ind)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        arg_d     = arg_q;
        ind_d     = ind_q;
        err_d     = err_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_push  = 1'b0;
        mem_pop   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_if.pc_load) pc_d = cmd_if.pc_value;
                if (cmd_if.cmd_valid) begin
                    data_d  = '0;
                    arg_d   = '0;
                    ind_d   = '0;
                    err_d   = 1'b0;
                    addr_d  = cmd_if.cmd_addr;
                    wdata_d = cmd_if.cmd_wdata;
                    case (cmd_op_e'(cmd_if.cmd_op))
                        CMD_FETCH: state_d = ST_F_OP;
                        CMD_LOAD: begin
                            state_d = ST_LOAD;
                            err_d   = oob(cmd_if.cmd_addr);
                        end
                        CMD_STORE: begin
                            state_d = ST_STORE;
                            err_d   = oob(cmd_if.cmd_addr);
                        end
                        CMD_PUSH: begin
                            state_d = ST_PUSH;
                            err_d   = (sp_q >= STACK_LIM);
                        end
                        CMD_POP: begin
                            state_d = ST_POP;
                            // Decrement up front so the POP cycle reads the top entry
                            if (sp_q == '0) err_d = 1'b1;
                            else            sp_d  = sp_q - 8'd1;
                        end
                        default: begin
                            state_d = ST_RESP;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_F_OP: begin
                pc_d = pc_q + 8'd1;
                if (oob(pc_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    mem_read = 1'b1;
                    mem_addr = pc_q;
                    data_d   = mem_rdata;
                    state_d  = has_arg ? ST_F_ARG : ST_RESP;
                end
            end
            ST_F_ARG: begin
                pc_d = pc_q + 8'd1;
                if (oob(pc_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    mem_read = 1'b1;
                    mem_addr = pc_q;
                    arg_d    = mem_rdata;
                    state_d  = has_ind ? ST_F_IND : ST_RESP;
                end
            end
            ST_F_IND: begin
                state_d = ST_RESP;
                if (oob(arg_q)) begin
                    err_d = 1'b1;
                end else begin
                    mem_read = 1'b1;
                    mem_addr = arg_q;
                    ind_d    = mem_rdata;
                end
            end
            ST_LOAD: begin
                state_d = ST_RESP;
                if (!err_q) begin
                    mem_read = 1'b1;
                    mem_addr = addr_q;
                    data_d   = mem_rdata;
                end
            end
            ST_STORE: begin
                state_d = ST_RESP;
                if (!err_q) begin
                    mem_write = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end
            end
            ST_PUSH: begin
                state_d = ST_RESP;
                if (!err_q) begin
                    mem_push  = 1'b1;
                    mem_wdata = wdata_q;
                    sp_d      = sp_q + 8'd1;
                end
            end
            ST_POP: begin
                state_d = ST_RESP;
                if (!err_q) begin
                    mem_pop = 1'b1;
                    data_d  = mem_rdata;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
            sp_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            arg_q   <= '0;
            ind_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            arg_q   <= arg_d;
            ind_q   <= ind_d;
            err_q   <= err_d;
        end
    end

    assign pc               = pc_q;
    assign sp               = sp_q;
    assign cmd_if.cmd_ready = cmd_ready;
    assign cmd_if.rsp_valid = rsp_valid;
    assign cmd_if.rsp_err   = rsp_err;
    assign cmd_if.rsp_data  = data_q;
    assign cmd_if.rsp_arg   = arg_q;
    assign cmd_if.rsp_ind   = ind_q;

endmodule
